// File: rtl/column_fade_drawer.sv
// Column highlighter for the VGA path: per-key columns light on press, hold, then fade to
// background. The pixel path has two register stages between x/display_enabled and r/g/b.
module column_fade_drawer #(
  parameter int unsigned NUM_COLS    = 7,
  parameter int unsigned COL_WIDTH   = 91,
  parameter int unsigned HOLD_FRAMES = 4,
  parameter int unsigned FADE_STEP   = 32,
  parameter logic [23:0] BG_COLOR    = 24'hFFFFFF,
  parameter logic [23:0] HIT_COLOR   = 24'hDDDDDD,
  parameter logic [23:0] LINE_COLOR  = 24'h000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                display_enabled_i,
  input  logic [9:0]          x_i,
  input  logic [8:0]          y_i,
  input  logic                frame_start_i,
  input  logic [NUM_COLS-1:0] key_array_i,
  output logic [7:0]          r_o,
  output logic [7:0]          g_o,
  output logic [7:0]          b_o
);

  localparam logic [8:0] IntMax   = 9'd256;
  localparam logic [8:0] FadeStep = 9'(FADE_STEP);
  localparam logic [7:0] HoldInit = 8'(HOLD_FRAMES);

  // Row position plays no part in the colour.
  logic unused_y;
  assign unused_y = ^y_i;

  logic [NUM_COLS-1:0] key_s1_q, key_s2_q, key_prev_q, key_rise;
  logic [NUM_COLS-1:0][8:0] intensity_q, intensity_d;
  logic [NUM_COLS-1:0][7:0] hold_q, hold_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q    <= '0;
      key_s2_q    <= '0;
      key_prev_q  <= '0;
      intensity_q <= '0;
      hold_q      <= '0;
    end else begin
      key_s1_q    <= key_array_i;
      key_s2_q    <= key_s1_q;
      key_prev_q  <= key_s2_q;
      intensity_q <= intensity_d;
      hold_q      <= hold_d;
    end
  end

  assign key_rise = key_s2_q & ~key_prev_q;

  // Intensity only moves on key activity or frame_start, so a fade never tears mid-frame.
  always_comb begin
    intensity_d = intensity_q;
    hold_d      = hold_q;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      if (key_rise[c] || key_s2_q[c]) begin
        intensity_d[c] = IntMax;
        hold_d[c]      = HoldInit;
      end else if (frame_start_i) begin
        if (hold_q[c] != 8'd0) begin
          hold_d[c] = hold_q[c] - 8'd1;
        end else if (intensity_q[c] > FadeStep) begin
          intensity_d[c] = intensity_q[c] - FadeStep;
        end else begin
          intensity_d[c] = 9'd0;
        end
      end
    end
  end

  // Stage 1: column decode and intensity lookup.
  logic [3:0] col;
  logic       line_hit, out_of_grid;
  logic [8:0] int_sel;

  always_comb begin
    col      = '0;
    line_hit = 1'b0;
    int_sel  = '0;
    for (int unsigned k = 0; k < NUM_COLS; k++) begin
      if (32'(x_i) >= k * COL_WIDTH) col = 4'(k);
    end
    for (int unsigned k = 0; k <= NUM_COLS; k++) begin
      if (32'(x_i) == k * COL_WIDTH) line_hit = 1'b1;
    end
    out_of_grid = 32'(x_i) > NUM_COLS * COL_WIDTH;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      if (col == 4'(c)) int_sel = intensity_q[c];
    end
  end

  logic       de_s1_q, line_s1_q, oog_s1_q;
  logic [8:0] int_s1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_s1_q   <= 1'b0;
      line_s1_q <= 1'b0;
      oog_s1_q  <= 1'b0;
      int_s1_q  <= '0;
    end else begin
      de_s1_q   <= display_enabled_i;
      line_s1_q <= line_hit;
      oog_s1_q  <= out_of_grid;
      int_s1_q  <= int_sel;
    end
  end

  // Stage 2: blend; weights sum to 256 so I=0 and I=256 land exactly on BG and HIT.
  function automatic logic [7:0] blend(input logic [7:0] bg, input logic [7:0] hit,
                                       input logic [8:0] i);
    logic [16:0] acc;
    acc = 17'(bg) * 17'(IntMax - i) + 17'(hit) * 17'(i);
    return 8'(acc >> 8);
  endfunction

  logic [23:0] rgb_d, rgb_q;

  always_comb begin
    rgb_d = '0;
    if (de_s1_q) begin
      if (line_s1_q) begin
        rgb_d = LINE_COLOR;
      end else if (oog_s1_q) begin
        rgb_d = BG_COLOR;
      end else begin
        rgb_d = {blend(BG_COLOR[23:16], HIT_COLOR[23:16], int_s1_q),
                 blend(BG_COLOR[15:8],  HIT_COLOR[15:8],  int_s1_q),
                 blend(BG_COLOR[7:0],   HIT_COLOR[7:0],   int_s1_q)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign r_o = rgb_q[23:16];
  assign g_o = rgb_q[15:8];
  assign b_o = rgb_q[7:0];

endmodule

// File: tb/tb_column_fade_drawer.sv
// Bench for column_fade_drawer: directed scenarios then random key/frame/pixel traffic,
// all checked against an event-level model of column intensities.
module tb_column_fade_drawer;

  localparam int NC   = 7;
  localparam int W    = 91;
  localparam int HOLD = 2;
  localparam int STEP = 32;
  localparam logic [23:0] BG  = 24'hFFFFFF;
  localparam logic [23:0] HIT = 24'hDDDDDD;
  localparam logic [23:0] LN  = 24'h000000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          de;
  logic [9:0]    x;
  logic [8:0]    y;
  logic          fs;
  logic [NC-1:0] keys;
  logic [7:0]    r, g, b;

  column_fade_drawer #(
    .NUM_COLS(NC), .COL_WIDTH(W), .HOLD_FRAMES(HOLD), .FADE_STEP(STEP),
    .BG_COLOR(BG), .HIT_COLOR(HIT), .LINE_COLOR(LN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .display_enabled_i(de), .x_i(x), .y_i(y),
    .frame_start_i(fs), .key_array_i(keys), .r_o(r), .g_o(g), .b_o(b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one intensity and hold count per column, updated per event.
  int m_i [NC];
  int m_h [NC];
  logic [NC-1:0] m_keys;

  task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int mix(input int bg, input int hit, input int i);
    return (bg * (256 - i) + hit * i) / 256;
  endfunction

  function automatic logic [23:0] model_rgb(input int xv, input bit dv);
    int i;
    if (!dv) return 24'h0;
    for (int k = 0; k <= NC; k++) if (xv == k * W) return LN;
    if (xv > NC * W) return BG;
    i = m_i[xv / W];
    return {8'(mix(BG[23:16], HIT[23:16], i)), 8'(mix(BG[15:8], HIT[15:8], i)),
            8'(mix(BG[7:0], HIT[7:0], i))};
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_i[c] = 0;
      m_h[c] = 0;
    end
  endfunction

  function automatic void model_keys(input logic [NC-1:0] k);
    m_keys = k;
    for (int c = 0; c < NC; c++) begin
      if (k[c]) begin
        m_i[c] = 256;
        m_h[c] = HOLD;
      end
    end
  endfunction

  function automatic void model_frame();
    for (int c = 0; c < NC; c++) begin
      if (!m_keys[c]) begin
        if (m_h[c] > 0) m_h[c]--;
        else m_i[c] = (m_i[c] > STEP) ? m_i[c] - STEP : 0;
      end
    end
  endfunction

  task automatic set_keys(input logic [NC-1:0] k);
    @(negedge clk);
    keys = k;
    repeat (4) @(posedge clk);
    model_keys(k);
  endtask

  task automatic frame();
    @(negedge clk);
    fs = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fs = 1'b0;
    model_frame();
  endtask

  task automatic probe(input int xv, input bit dv, input string tag, input logic [23:0] exp);
    @(negedge clk);
    x  = 10'(xv);
    de = dv;
    y  = 9'($urandom_range(0, 479));
    repeat (2) @(posedge clk);
    #1;
    check_eq(tag, {r, g, b}, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    de = 1'b0; x = '0; y = '0; fs = 1'b0; keys = '0;
    model_reset();
    m_keys = '0;
    #1;
    check_eq("reset_rgb", {r, g, b}, 24'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Grid lines, column interiors, right margin, blanking.
    probe(0,   1, "grid_x0",   24'h000000);
    probe(91,  1, "grid_x91",  24'h000000);
    probe(182, 1, "grid_x182", 24'h000000);
    probe(637, 1, "grid_x637", 24'h000000);
    probe(90,  1, "col_x90",   24'hFFFFFF);
    probe(639, 1, "oog_x639",  24'hFFFFFF);
    probe(300, 0, "blank",     24'h000000);

    // Press key 2.
    set_keys(7'b0000100);
    probe(200, 1, "press_col2", 24'hDDDDDD);
    probe(100, 1, "press_col1", 24'hFFFFFF);
    probe(500, 1, "press_col5", 24'hFFFFFF);

    // Release, hold for HOLD frames, then fade and saturate at 0.
    set_keys('0);
    for (int f = 1; f <= 12; f++) begin
      logic [23:0] e;
      frame();
      e = model_rgb(200, 1);
      if (f <= 2) e = 24'hDDDDDD;
      if (f == 3) e = 24'hE1E1E1;
      if (f == 6) e = 24'hEEEEEE;
      if (f >= 10) e = 24'hFFFFFF;
      probe(200, 1, $sformatf("fade_f%0d", f), e);
    end

    // Rising edge in the same cycle as frame_start on key 5.
    @(negedge clk);
    keys = 7'b0100000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    fs = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fs = 1'b0;
    repeat (2) @(posedge clk);
    model_keys(7'b0100000);
    probe(465, 1, "collide_hit", 24'hDDDDDD);
    set_keys('0);
    frame();
    frame();
    probe(465, 1, "collide_hold", 24'hDDDDDD);
    frame();
    probe(465, 1, "collide_fade", 24'hE1E1E1);

    // Re-press at I=96.
    repeat (4) frame();
    probe(465, 1, "fade_96", 24'hF2F2F2);
    set_keys(7'b0100000);
    probe(465, 1, "repress", 24'hDDDDDD);
    set_keys('0);
    frame();
    probe(465, 1, "repress_hold", 24'hDDDDDD);

    // Reset mid-line with a lit column.
    set_keys(7'b0000100);
    set_keys('0);
    probe(200, 1, "pre_reset", 24'hDDDDDD);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("reset_now", {r, g, b}, 24'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("reset_rel1", {r, g, b}, 24'h0);
    @(posedge clk);
    #1;
    check_eq("reset_rel2", {r, g, b}, 24'hFFFFFF);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int op;
      op = $urandom_range(0, 7);
      if (op == 0) begin
        set_keys(NC'($urandom) & NC'($urandom));
      end else if (op <= 2) begin
        frame();
      end else begin
        int xv;
        bit dv;
        xv = $urandom_range(0, 1023);
        dv = ($urandom_range(0, 3) != 0);
        probe(xv, dv, $sformatf("rand_x%0d", xv), model_rgb(xv, dv));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
